exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Multi-cycle execute sequencer that sits around the combinational ALU.
- Upstream side: accepts a 16-bit instruction, reads operands from an internal 8x16 register file, applies the barrel shift, and drives Ain, Bin and ALUop into the ALU.
- Downstream side: captures the ALU result into C and the VNZ flags into a status register, then writes the result back.
- Provides a start/wait handshake toward the fetch/control logic.

Parameters:
- DW, 16, datapath width; register file entries, A, B, C, Ain and Bin are all DW wide.
- NREG, 8, register file depth; indexed by 3-bit register fields.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- s  input  1  start; sampled only in IDLE
- instr  input  16  instruction word; captured when s is accepted
- w  output  1  waiting; 1 only in IDLE
- Ain  output  16  ALU operand A
- Bin  output  16  ALU operand B, after shift
- ALUop  output  2  ALU operation select
- alu_out  input  16  ALU result
- alu_z  input  3  ALU flags, {V,N,Z}
- status  output  3  latched {V,N,Z}
- datapath_out  output  16  contents of register C
- illegal  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - IR, A, B, C, status and all register file entries go to 0.
  - w=1, illegal=0.
  - Ain and Bin are 0 while A and B are 0.
  - Reset asserted mid-instruction aborts it; no partial write survives.
- Instruction decode (IR fields):
  - opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
  - sximm8 = IR[7:0] sign-extended to DW.
- Supported instructions:
  - 110/10: MOV Rn,#imm8.
  - 110/00: MOV Rd,Rm{,sh}.
  - 101/00: ADD Rd,Rn,Rm{,sh}.
  - 101/01: CMP Rn,Rm{,sh}.
  - 101/10: AND Rd,Rn,Rm{,sh}.
  - 101/11: MVN Rd,Rm{,sh}.
  - Any other opcode/op combination is illegal.
- Shifter (combinational on B):
  - sh=00: pass through.
  - sh=01: LSL 1, shifting in 0.
  - sh=10: LSR 1, shifting in 0 at the MSB.
  - sh=11: ASR 1, copying B[15] into the MSB.
- Operand drive:
  - Ain = 0 for MOV-reg, A otherwise.
  - Bin = shift(B).
  - ALUop = op for opcode 101; 00 for MOV-reg.
  - Outputs are valid in every state; the ALU is sampled only in EXEC.
- States: IDLE, DECODE, GET_A, GET_B, EXEC, WRITE, WRITE_IMM.
- Transitions:
  - IDLE: on s=1, IR<=instr and go to DECODE. On s=0, stay. w=1 only here.
  - DECODE:
    - MOV-imm -> WRITE_IMM.
    - MOV-reg or MVN -> GET_B.
    - ADD/CMP/AND -> GET_A.
    - Illegal -> IDLE with illegal=1 for one cycle; no state is modified.
  - GET_A: A<=R[Rn] -> GET_B.
  - GET_B: B<=R[Rm] -> EXEC.
  - EXEC:
    - C<=alu_out.
    - CMP only: status<=alu_z, then -> IDLE.
    - All other instructions: status unchanged, then -> WRITE.
  - WRITE: R[Rd]<=C -> IDLE.
  - WRITE_IMM: R[Rn]<=sximm8 -> IDLE.
- Latency (s accepted at edge 0; w returns high after the listed edge):
  - ADD/AND: 5 edges.
  - CMP: 4 edges.
  - MOV-reg/MVN: 4 edges.
  - MOV-imm: 2 edges.
- Width rules:
  - All arithmetic is modulo 2^DW.
  - Only status[2:0] as produced by the ALU are latched; V is whatever the ALU reports (currently always 0).
- Boundary conditions:
  - s asserted outside IDLE is ignored.
  - instr changes after capture have no effect.
  - Rd==Rn or Rd==Rm is legal; reads complete before WRITE.
  - Register read and write in the same cycle cannot occur: reads happen only in GET_A/GET_B, writes only in WRITE/WRITE_IMM.
  - C is not cleared between instructions.
  - illegal is held 0 in all cycles except the one after an illegal DECODE.

Test Plan:
- Reset mid-ADD in EXEC, then release -> state IDLE, w=1, datapath_out=0, status=000, R0..R7 all read back 0.
- MOV R0,#7; MOV R1,#-2 (imm8=0xFE) -> R0=0x0007, R1=0xFFFE; w high 2 edges after each s.
- ADD R2,R0,R1 with sh=01 -> Bin=0xFFFC, C=R2=0x0003, status unchanged, w high 5 edges after s.
- CMP R0,R0 -> status=001, no register write. CMP R1,R0 -> status=010 (0xFFF7 is negative).
- MVN R3,R0 with sh=11 and R0=0x8000 -> Bin=0xC000, R3=0x3FFF. MOV R4,R1 with sh=10 -> R4=0x7FFF.
- Illegal opcode 111 -> illegal pulses exactly 1 cycle, all registers and status unchanged. s toggled during a busy ADD is ignored, and exactly one instruction completes.

Source files
------------

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle execute sequencer wrapped around an external
// combinational ALU. Owns the instruction register, an 8-entry register file,
// the A/B/C operand/result registers and the latched {V,N,Z} status.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset, clears all state
//   s            start request, only looked at while waiting in IDLE
//   instr        instruction word, captured when s is accepted
//   w            high only while idle and ready for a new instruction
//   Ain, Bin     ALU operands (Bin already passed through the shifter)
//   ALUop        ALU operation select
//   alu_out      ALU result
//   alu_z        ALU flags {V,N,Z}
//   status       latched {V,N,Z} (only CMP updates it)
//   datapath_out contents of result register C
//   illegal      one-cycle pulse after decoding an undefined instruction
module exec_sequencer #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic [15:0]   instr,
  output logic          w,
  output logic [DW-1:0] Ain,
  output logic [DW-1:0] Bin,
  output logic [1:0]    ALUop,
  input  logic [DW-1:0] alu_out,
  input  logic [2:0]    alu_z,
  output logic [2:0]    status,
  output logic [DW-1:0] datapath_out,
  output logic          illegal
);

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MVN     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE,
    S_WRITE_IMM
  } state_t;

  state_t        r_state;
  logic [15:0]   r_ir;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_c;
  logic [2:0]    r_status;
  logic          r_w;
  logic          r_illegal;
  logic [DW-1:0] r_rf [NREG];

  // Instruction field decode from the captured IR
  logic [2:0]    w_opcode;
  logic [1:0]    w_op;
  logic [2:0]    w_rn;
  logic [2:0]    w_rd;
  logic [1:0]    w_sh;
  logic [2:0]    w_rm;
  logic [DW-1:0] w_sximm8;
  logic          w_is_mov_imm;
  logic          w_is_mov_reg;
  logic          w_is_alu;
  logic          w_is_cmp;
  logic          w_is_mvn;
  logic [DW-1:0] w_shifted;

  assign w_opcode = r_ir[15:13];
  assign w_op     = r_ir[12:11];
  assign w_rn     = r_ir[10:8];
  assign w_rd     = r_ir[7:5];
  assign w_sh     = r_ir[4:3];
  assign w_rm     = r_ir[2:0];
  assign w_sximm8 = {{(DW-8){r_ir[7]}}, r_ir[7:0]};

  assign w_is_mov_imm = (w_opcode == OPC_MOV) && (w_op == OP_MOV_IMM);
  assign w_is_mov_reg = (w_opcode == OPC_MOV) && (w_op == OP_MOV_REG);
  assign w_is_alu     = (w_opcode == OPC_ALU);
  assign w_is_cmp     = w_is_alu && (w_op == OP_CMP);
  assign w_is_mvn     = w_is_alu && (w_op == OP_MVN);

  // Single-bit barrel shifter on operand B
  always_comb begin
    w_shifted = r_b;
    case (w_sh)
      2'b00:   w_shifted = r_b;
      2'b01:   w_shifted = {r_b[DW-2:0], 1'b0};
      2'b10:   w_shifted = {1'b0, r_b[DW-1:1]};
      default: w_shifted = {r_b[DW-1], r_b[DW-1:1]};
    endcase
  end

  // MOV-reg is executed as 0 + shift(B) through the ALU's add path
  assign Ain          = w_is_mov_reg ? '0 : r_a;
  assign Bin          = w_shifted;
  assign ALUop        = w_is_alu ? w_op : 2'b00;
  assign status       = r_status;
  assign datapath_out = r_c;
  assign w            = r_w;
  assign illegal      = r_illegal;

  // Sequencer FSM with datapath register updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_status  <= '0;
      r_w       <= 1'b1;
      r_illegal <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (s) begin
            r_ir    <= instr;
            r_state <= S_DECODE;
            r_w     <= 1'b0;
          end
        end
        S_DECODE: begin
          if (w_is_mov_imm) begin
            r_state <= S_WRITE_IMM;
          end else if (w_is_mov_reg || w_is_mvn) begin
            r_state <= S_GET_B;
          end else if (w_is_alu) begin
            r_state <= S_GET_A;
          end else begin
            // Undefined encoding: abandon without touching any state
            r_state   <= S_IDLE;
            r_w       <= 1'b1;
            r_illegal <= 1'b1;
          end
        end
        S_GET_A: begin
          r_a     <= r_rf[w_rn];
          r_state <= S_GET_B;
        end
        S_GET_B: begin
          r_b     <= r_rf[w_rm];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_c <= alu_out;
          if (w_is_cmp) begin
            r_status <= alu_z;
            r_state  <= S_IDLE;
            r_w      <= 1'b1;
          end else begin
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_rf[w_rd] <= r_c;
          r_state    <= S_IDLE;
          r_w        <= 1'b1;
        end
        S_WRITE_IMM: begin
          r_rf[w_rn] <= w_sximm8;
          r_state    <= S_IDLE;
          r_w        <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_w     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed instruction stream against exec_sequencer with
// a behavioural ALU. Expected results are queued at issue time and checked by
// a monitor whenever an instruction completes (w returns high).
module tb_exec_sequencer;

  logic        clk;
  logic        reset;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic [1:0]  ALUop;
  logic [15:0] alu_out;
  logic [2:0]  alu_z;
  logic [2:0]  status;
  logic [15:0] datapath_out;
  logic        illegal;

  int total = 0;
  int bad   = 0;
  int ill_seen = 0;

  typedef struct {
    logic [15:0] dout;
    logic [2:0]  st;
    int          lat;
    logic        ill;
    int          bin_at;
    logic [15:0] bin;
  } exp_t;

  exp_t sb_q[$];

  exec_sequencer #(.DW(16), .NREG(8)) dut (
    .clk(clk), .reset(reset), .s(s), .instr(instr), .w(w),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .alu_out(alu_out), .alu_z(alu_z),
    .status(status), .datapath_out(datapath_out), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: ADD, SUB, AND, NOT B; flags {V=0,N,Z}
  always_comb begin
    case (ALUop)
      2'b00:   alu_out = Ain + Bin;
      2'b01:   alu_out = Ain - Bin;
      2'b10:   alu_out = Ain & Bin;
      default: alu_out = ~Bin;
    endcase
    alu_z = {1'b0, alu_out[15], (alu_out == 16'h0000)};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] opc, input logic [1:0] op,
                                      input logic [2:0] rn, input logic [2:0] rd,
                                      input logic [1:0] sh, input logic [2:0] rm);
    return {opc, op, rn, rd, sh, rm};
  endfunction

  function automatic logic [15:0] enc_imm(input logic [2:0] rn, input logic [7:0] imm8);
    return {3'b110, 2'b10, rn, imm8};
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (w !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (w !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wait_idle actual=w_%b expected=w_1", w);
    end
  endtask

  task automatic issue(input logic [15:0] ins, input logic [15:0] dout, input logic [2:0] st,
                       input int lat, input logic ill, input int bin_at, input logic [15:0] bin);
    exp_t e;
    @(negedge clk);
    wait_idle();
    e.dout = dout; e.st = st; e.lat = lat; e.ill = ill; e.bin_at = bin_at; e.bin = bin;
    sb_q.push_back(e);
    s = 1'b1;
    instr = ins;
    @(negedge clk);
    s = 1'b0;
    instr = 16'($urandom);
  endtask

  // Completion monitor
  initial begin
    bit busy = 0;
    int cnt = 0;
    int ncomp = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        busy = 0;
      end else begin
        if (illegal) ill_seen++;
        if (!busy) begin
          if (!w) begin
            busy = 1;
            cnt = 0;
          end
        end else begin
          cnt++;
          if (sb_q.size() > 0 && sb_q[0].bin_at == cnt)
            chk($sformatf("bin_%0d", ncomp), 32'(Bin), 32'(sb_q[0].bin));
          if (w) begin
            busy = 0;
            if (sb_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_completion actual=1 expected=0");
            end else begin
              e = sb_q.pop_front();
              chk($sformatf("dout_%0d", ncomp), 32'(datapath_out), 32'(e.dout));
              chk($sformatf("status_%0d", ncomp), 32'(status), 32'(e.st));
              chk($sformatf("latency_%0d", ncomp), 32'(cnt), 32'(e.lat));
              chk($sformatf("illegal_%0d", ncomp), 32'(illegal), 32'(e.ill));
            end
            ncomp++;
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    s = 1'b0;
    instr = 16'h0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_w", 32'(w), 32'h1);
    chk("rst_dout", 32'(datapath_out), 32'h0);
    chk("rst_status", 32'(status), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_ain", 32'(Ain), 32'h0);
    chk("rst_bin", 32'(Bin), 32'h0);

    // Build up non-zero state, then abort an ADD in EXEC with reset
    issue(enc_imm(3'd0, 8'h05), 16'h0000, 3'b000, 2, 1'b0, 0, 16'h0);
    issue(enc(3'b101, 2'b01, 3'd0, 3'd0, 2'b00, 3'd0), 16'h0000, 3'b001, 4, 1'b0, 0, 16'h0);
    issue(enc(3'b101, 2'b00, 3'd0, 3'd1, 2'b00, 3'd0), 16'h000A, 3'b001, 5, 1'b0, 3, 16'h0005);
    @(negedge clk);
    wait_idle();
    s = 1'b1;
    instr = enc(3'b101, 2'b00, 3'd1, 3'd2, 2'b00, 3'd0);
    @(negedge clk);
    s = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_w", 32'(w), 32'h1);
    chk("abort_dout", 32'(datapath_out), 32'h0);
    chk("abort_status", 32'(status), 32'h0);
    for (int k = 0; k < 8; k++)
      issue(enc(3'b110, 2'b00, 3'd0, 3'(k), 2'b00, 3'(k)), 16'h0000, 3'b000, 4, 1'b0, 0, 16'h0);

    // MOV immediates, ADD with LSL, CMP flags
    issue(enc_imm(3'd0, 8'h07), 16'h0000, 3'b000, 2, 1'b0, 0, 16'h0);
    issue(enc_imm(3'd1, 8'hFE), 16'h0000, 3'b000, 2, 1'b0, 0, 16'h0);
    issue(enc(3'b110, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0), 16'h0007, 3'b000, 4, 1'b0, 0, 16'h0);
    issue(enc(3'b110, 2'b00, 3'd0, 3'd1, 2'b00, 3'd1), 16'hFFFE, 3'b000, 4, 1'b0, 0, 16'h0);
    issue(enc(3'b101, 2'b00, 3'd0, 3'd2, 2'b01, 3'd1), 16'h0003, 3'b000, 5, 1'b0, 3, 16'hFFFC);
    issue(enc(3'b110, 2'b00, 3'd0, 3'd2, 2'b00, 3'd2), 16'h0003, 3'b000, 4, 1'b0, 0, 16'h0);
    issue(enc(3'b101, 2'b01, 3'd0, 3'd0, 2'b00, 3'd0), 16'h0000, 3'b001, 4, 1'b0, 0, 16'h0);
    issue(enc(3'b101, 2'b01, 3'd1, 3'd0, 2'b00, 3'd0), 16'hFFF7, 3'b010, 4, 1'b0, 0, 16'h0);

    // Make R0 = 0x8000 (FFFF, LSR, MVN), then shifted MVN / MOV
    issue(enc_imm(3'd0, 8'hFF), 16'hFFF7, 3'b010, 2, 1'b0, 0, 16'h0);
    issue(enc(3'b110, 2'b00, 3'd0, 3'd0, 2'b10, 3'd0), 16'h7FFF, 3'b010, 4, 1'b0, 2, 16'h7FFF);
    issue(enc(3'b101, 2'b11, 3'd0, 3'd0, 2'b00, 3'd0), 16'h8000, 3'b010, 4, 1'b0, 0, 16'h0);
    issue(enc(3'b101, 2'b11, 3'd0, 3'd3, 2'b11, 3'd0), 16'h3FFF, 3'b010, 4, 1'b0, 2, 16'hC000);
    issue(enc(3'b110, 2'b00, 3'd0, 3'd4, 2'b10, 3'd1), 16'h7FFF, 3'b010, 4, 1'b0, 2, 16'h7FFF);
    issue(enc(3'b110, 2'b00, 3'd0, 3'd3, 2'b00, 3'd3), 16'h3FFF, 3'b010, 4, 1'b0, 0, 16'h0);

    // Illegal encodings leave everything alone
    issue(16'hE123, 16'h3FFF, 3'b010, 1, 1'b1, 0, 16'h0);
    issue(enc(3'b110, 2'b01, 3'd5, 3'd5, 2'b00, 3'd0), 16'h3FFF, 3'b010, 1, 1'b1, 0, 16'h0);
    issue(enc(3'b110, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0), 16'h8000, 3'b010, 4, 1'b0, 0, 16'h0);
    issue(enc(3'b110, 2'b00, 3'd0, 3'd1, 2'b00, 3'd1), 16'hFFFE, 3'b010, 4, 1'b0, 0, 16'h0);
    issue(enc(3'b110, 2'b00, 3'd0, 3'd2, 2'b00, 3'd2), 16'h0003, 3'b010, 4, 1'b0, 0, 16'h0);
    issue(enc(3'b110, 2'b00, 3'd0, 3'd4, 2'b00, 3'd4), 16'h7FFF, 3'b010, 4, 1'b0, 0, 16'h0);

    // ADD R5,R0,R4 with s and instr wiggling while busy
    @(negedge clk);
    wait_idle();
    begin
      exp_t e;
      e.dout = 16'hFFFF; e.st = 3'b010; e.lat = 5; e.ill = 1'b0; e.bin_at = 3; e.bin = 16'h7FFF;
      sb_q.push_back(e);
    end
    s = 1'b1;
    instr = enc(3'b101, 2'b00, 3'd0, 3'd5, 2'b00, 3'd4);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      s = (i % 2 == 0);
      instr = enc_imm(3'd6, 8'h09);
      @(negedge clk);
    end
    s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("busy_idle_%0d", i), 32'(w), 32'h1);
    end
    issue(enc(3'b110, 2'b00, 3'd0, 3'd5, 2'b00, 3'd5), 16'hFFFF, 3'b010, 4, 1'b0, 0, 16'h0);
    issue(enc(3'b110, 2'b00, 3'd0, 3'd6, 2'b00, 3'd6), 16'h0000, 3'b010, 4, 1'b0, 0, 16'h0);
    issue(enc(3'b101, 2'b10, 3'd5, 3'd7, 2'b00, 3'd1), 16'hFFFE, 3'b010, 5, 1'b0, 0, 16'h0);
    issue(enc(3'b110, 2'b00, 3'd0, 3'd7, 2'b00, 3'd7), 16'hFFFE, 3'b010, 4, 1'b0, 0, 16'h0);

    begin
      int n = 0;
      while (sb_q.size() > 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("queue_drained", 32'(sb_q.size()), 32'h0);
    end
    repeat (2) @(negedge clk);
    chk("illegal_cycles", 32'(ill_seen), 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
